// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock into DIGITS packed
// BCD digits, with start/busy/done handshake and saturation past 10^DIGITS-1.

module bin_to_bcd_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);

  function automatic longint unsigned pow10_m1(input int n);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v - 1;
  endfunction

  localparam int              CW      = $clog2(BIN_WIDTH + 1);
  localparam int              SW      = 4 * DIGITS + BIN_WIDTH;
  localparam longint unsigned MAX_VAL = pow10_m1(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [BIN_WIDTH-1:0]    bin_sr;
  logic [DIGITS-1:0][3:0]  scratch;
  logic [DIGITS-1:0][3:0]  adj;
  logic [CW-1:0]           cnt;
  logic                    ovf_pending;
  logic                    accept;
  logic [SW-1:0]           shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin_to_bcd_digit u_dig (.d(scratch[g]), .q(adj[g]));
  end

  assign accept  = start && (state == IDLE || state == DONE);
  // Add-3 happens before the shift; the top digit's carry-out falls off the end.
  assign shifted = {adj, bin_sr} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bin_sr      <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      bcd_out     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            bin_sr      <= bin_in;
            scratch     <= '0;
            cnt         <= CW'(BIN_WIDTH);
            ovf_pending <= 64'(bin_in) > MAX_VAL;
            busy        <= 1'b1;
            state       <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            scratch <= shifted[SW-1 -: 4*DIGITS];
            bin_sr  <= shifted[BIN_WIDTH-1:0];
            cnt     <= cnt - 1'b1;
          end else begin
            bcd_out  <= ovf_pending ? {DIGITS{4'h9}} : scratch;
            overflow <= ovf_pending;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
